// File: rtl/rot_arb_pkg.sv
// Shared constants and the rotate helper for the rotating arbiter.
package rot_arb_pkg;
    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;
    localparam int ID_W   = 3;

    localparam logic ROT_R = 1'b0;
    localparam logic ROT_L = 1'b1;

    // Rotate right: y[k] = a[(k+s) mod DATA_W].
    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] a,
                                               input logic [AMT_W-1:0]  s);
        logic [DATA_W-1:0] y;
        y = '0;
        for (int k = 0; k < DATA_W; k++) begin
            y[k] = a[(k + int'(s)) % DATA_W];
        end
        return y;
    endfunction
endpackage

// File: rtl/rot_arb_rr_arb.sv
// Round-robin grant: first requester above 'last' (with wrap) wins while enabled.
module rr_arb
    import rot_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    input  logic            en,
    output logic [NREQ-1:0] grant
);
    // Search upward from last+1, wrapping at NREQ; only the first hit is granted.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (en) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(last) + k) % NREQ;
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/rot_arb.sv
// Round-robin arbiter feeding a single-slot rotate result register.
module rot_arb
    import rot_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [DATA_W*NREQ-1:0] req_data,
    input  logic [AMT_W*NREQ-1:0]  req_amt,
    input  logic [NREQ-1:0]        req_dir,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   rsp_ready,
    output logic [CNTW-1:0]        op_cnt
);
    logic              slot_free;
    logic              arb_en;
    logic              xfer;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   gnt_id;
    logic [DATA_W-1:0] sel_data;
    logic [AMT_W-1:0]  sel_amt;
    logic              sel_dir;
    logic [AMT_W-1:0]  shift;
    logic [DATA_W-1:0] rot_data;

    // Slot frees when empty or when the held result leaves this cycle.
    assign slot_free = !rsp_valid || rsp_ready;
    // rst_n gating keeps req_ready low throughout reset.
    assign arb_en    = slot_free && rst_n;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .last  (last),
        .en    (arb_en),
        .grant (grant)
    );

    assign req_ready = grant;
    assign xfer      = |(grant & req_valid);

    // Encode the grant and steer the winner's operands into the rotator.
    always_comb begin
        gnt_id   = '0;
        sel_data = '0;
        sel_amt  = '0;
        sel_dir  = ROT_R;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_id   = ID_W'(i);
                sel_data = req_data[DATA_W*i +: DATA_W];
                sel_amt  = req_amt[AMT_W*i +: AMT_W];
                sel_dir  = req_dir[i];
            end
        end
    end

    // Left by s is right by (8-s) mod 8; 3-bit negate gives exactly that.
    assign shift    = (sel_dir == ROT_L) ? (AMT_W'(0) - sel_amt) : sel_amt;
    assign rot_data = rotr(sel_data, shift);

    // Result slot: load on transfer, clear on bare acceptance, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rot_data;
            rsp_id    <= gnt_id;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer follows the last granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= ID_W'(NREQ - 1);
        end else if (xfer) begin
            last <= gnt_id;
        end
    end

    // Count results accepted downstream; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt <= '0;
        end else if (rsp_valid && rsp_ready) begin
            op_cnt <= op_cnt + 1'b1;
        end
    end
endmodule
